// File: rtl/lsu_if.sv
// lsu_if: handshake and bus bundle for the load/store unit.
//   in_*  : execute-stage request (valid/ready, store flag, funct3, addr, wdata)
//   mem_* : single-beat data-bus request/response
//   out_* : writeback result (valid/ready, data, fault)
// Modport slave is the LSU side; modport master is the surrounding
// pipeline/bus side (execute stage, memory and writeback together).
interface lsu_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_store;
  logic [2:0]            in_funct3;
  logic [WIDTH-1:0]      in_addr;
  logic [WIDTH-1:0]      in_wdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_fault;

  modport slave (
    input  in_valid, in_store, in_funct3, in_addr, in_wdata,
    output in_ready,
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata,
    output out_valid, out_data, out_fault,
    input  out_ready
  );

  modport master (
    output in_valid, in_store, in_funct3, in_addr, in_wdata,
    input  in_ready,
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata,
    input  out_valid, out_data, out_fault,
    output out_ready
  );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit between the ALU and writeback.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : lsu_if.slave (execute request, data-bus request, writeback result)
// One bus transaction per instruction; misaligned or illegal-funct3 ops
// skip the bus and return a fault with zero data.
//
// state | meaning
// IDLE  | in_ready high, waiting for an op
// BUS   | mem_valid high, request held until mem_ready
// RESP  | out_valid high, result held until out_ready
module lsu #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  fault_q, fault_d;

  logic [1:0]            in_off;
  logic                  legal;
  logic                  misaligned;
  logic [3:0]            strb_c;
  logic [WIDTH-1:0]      lanes_c;
  logic [WIDTH-1:0]      shifted;
  logic [WIDTH-1:0]      load_ext;

  assign in_off = bus.in_addr[1:0];

  // Request decode on the raw inputs; only meaningful while accepting.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    strb_c     = 4'b1111;
    lanes_c    = bus.in_wdata;
    if (bus.in_store) begin
      legal = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
              (bus.in_funct3 == 3'b010);
    end else begin
      legal = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
              (bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b100) ||
              (bus.in_funct3 == 3'b101);
    end
    case (bus.in_funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << in_off;
        lanes_c = {4{bus.in_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = in_off[0];
        strb_c     = 4'b0011 << in_off;
        lanes_c    = {2{bus.in_wdata[15:0]}};
      end
      default: begin
        misaligned = (in_off != 2'b00);
        strb_c     = 4'b1111;
        lanes_c    = bus.in_wdata;
      end
    endcase
  end

  // Load alignment and extension from the captured offset/funct3.
  always_comb begin
    shifted  = bus.mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    out_data_d = out_data_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          addr_d     = {bus.in_addr[ADDR_WIDTH-1:2], 2'b00};
          we_d       = bus.in_store;
          wstrb_d    = bus.in_store ? strb_c : 4'b0000;
          wdata_d    = lanes_c;
          funct3_d   = bus.in_funct3;
          off_d      = in_off;
          out_data_d = '0;
          if (!legal || misaligned) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            fault_d = 1'b0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (bus.mem_ready) begin
          out_data_d = we_q ? '0 : load_ext;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= '0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      out_data_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      out_data_q <= out_data_d;
      fault_q    <= fault_d;
    end
  end

  // Valids decode straight from the state flop so reset drops them at once.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_valid = (state_q == BUS);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.out_valid = (state_q == RESP);
  assign bus.out_data  = out_data_q;
  assign bus.out_fault = fault_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu #(.WIDTH(32), .ADDR_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        use_bus;
    logic [31:0] eaddr;
    logic [3:0]  estrb;
    logic [31:0] ewdata;
    logic [31:0] edata;
    logic        efault;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string n, logic st, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic ub,
                              logic [31:0] ea, logic [3:0] es, logic [31:0] ew,
                              logic [31:0] ed, logic ef);
    vec_t v;
    v.name = n; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.use_bus = ub; v.eaddr = ea; v.estrb = es; v.ewdata = ew; v.edata = ed; v.efault = ef;
    return v;
  endfunction

  // Called at a negedge with the LSU idle; returns at a negedge with it idle again.
  task automatic run_vec(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_store  = v.st;
    bus.in_funct3 = v.f3;
    bus.in_addr   = v.addr;
    bus.in_wdata  = v.wdata;
    bus.mem_rdata = v.rdata;
    bus.mem_ready = 1'b1;
    bus.out_ready = 1'b1;
    chk({v.name, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (v.use_bus) begin
      chk({v.name, " mem_valid"}, {31'd0, bus.mem_valid}, 32'd1);
      chk({v.name, " mem_addr"}, bus.mem_addr, v.eaddr);
      chk({v.name, " mem_we"}, {31'd0, bus.mem_we}, {31'd0, v.st});
      chk({v.name, " mem_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, v.estrb});
      if (v.st) chk({v.name, " mem_wdata"}, bus.mem_wdata, v.ewdata);
      chk({v.name, " early out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({v.name, " mem_valid after"}, {31'd0, bus.mem_valid}, 32'd0);
    end else begin
      chk({v.name, " no mem_valid"}, {31'd0, bus.mem_valid}, 32'd0);
    end
    chk({v.name, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({v.name, " out_data"}, bus.out_data, v.edata);
    chk({v.name, " out_fault"}, {31'd0, bus.out_fault}, {31'd0, v.efault});
    chk({v.name, " in_ready resp"}, {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, " back idle"}, {31'd0, bus.in_ready}, 32'd1);
    chk({v.name, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    bus.mem_ready = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] hold_addr;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_store  = 1'b0;
    bus.in_funct3 = 3'b000;
    bus.in_addr   = '0;
    bus.in_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.out_ready = 1'b0;

    vecs[0]  = mk("LW",      0, 3'b010, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 1, 32'h1004, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0);
    vecs[1]  = mk("LB",      0, 3'b000, 32'h0000_2003, 32'h0,         32'h80FF_0000, 1, 32'h2000, 4'b0000, 32'h0,         32'hFFFF_FF80, 0);
    vecs[2]  = mk("LBU",     0, 3'b100, 32'h0000_2003, 32'h0,         32'h80FF_0000, 1, 32'h2000, 4'b0000, 32'h0,         32'h0000_0080, 0);
    vecs[3]  = mk("LH",      0, 3'b001, 32'h0000_2002, 32'h0,         32'h80FF_0000, 1, 32'h2000, 4'b0000, 32'h0,         32'hFFFF_80FF, 0);
    vecs[4]  = mk("LHU",     0, 3'b101, 32'h0000_2002, 32'h0,         32'h80FF_0000, 1, 32'h2000, 4'b0000, 32'h0,         32'h0000_80FF, 0);
    vecs[5]  = mk("SB",      1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 32'h3000, 4'b0010, 32'hABAB_ABAB, 32'h0,         0);
    vecs[6]  = mk("SH",      1, 3'b001, 32'h0000_3002, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 32'h3000, 4'b1100, 32'h56AB_56AB, 32'h0,         0);
    vecs[7]  = mk("SW",      1, 3'b010, 32'h0000_3004, 32'h1234_5678, 32'hFFFF_FFFF, 1, 32'h3004, 4'b1111, 32'h1234_5678, 32'h0,         0);
    vecs[8]  = mk("LW mis",  0, 3'b010, 32'h0000_1002, 32'h0,         32'hFFFF_FFFF, 0, 32'h0,    4'b0000, 32'h0,         32'h0,         1);
    vecs[9]  = mk("SH mis",  1, 3'b001, 32'h0000_1001, 32'h5555_5555, 32'hFFFF_FFFF, 0, 32'h0,    4'b0000, 32'h0,         32'h0,         1);
    vecs[10] = mk("L f3=110",0, 3'b110, 32'h0000_1000, 32'h0,         32'hFFFF_FFFF, 0, 32'h0,    4'b0000, 32'h0,         32'h0,         1);
    vecs[11] = mk("S f3=100",1, 3'b100, 32'h0000_1000, 32'h0,         32'hFFFF_FFFF, 0, 32'h0,    4'b0000, 32'h0,         32'h0,         1);
    vecs[12] = mk("LB pos",  0, 3'b000, 32'h0000_2001, 32'h0,         32'h0000_7F00, 1, 32'h2000, 4'b0000, 32'h0,         32'h0000_007F, 0);
    vecs[13] = mk("LH lo",   0, 3'b001, 32'h0000_2000, 32'h0,         32'h1234_8001, 1, 32'h2000, 4'b0000, 32'h0,         32'hFFFF_8001, 0);

    // Reset state
    #3;
    chk("rst mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst mem_addr",  bus.mem_addr, 32'd0);
    chk("rst wstrb",     {28'd0, bus.mem_wstrb}, 32'd0);
    chk("rst out_data",  bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Stalls: mem_ready low 5 cycles, out_ready low 3 cycles
    bus.in_valid  = 1'b1;
    bus.in_store  = 1'b0;
    bus.in_funct3 = 3'b010;
    bus.in_addr   = 32'h0000_4008;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    // Junk on in_* must be ignored outside IDLE.
    bus.in_store  = 1'b1;
    bus.in_funct3 = 3'b000;
    bus.in_addr   = 32'h0000_5555;
    hold_addr = 32'h0000_4008;
    for (int c = 0; c < 5; c++) begin
      chk("stall mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      chk("stall mem_addr",  bus.mem_addr, hold_addr);
      chk("stall mem_we",    {31'd0, bus.mem_we}, 32'd0);
      chk("stall in_ready",  {31'd0, bus.in_ready}, 32'd0);
      chk("stall out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rstall out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("rstall out_data",  bus.out_data, 32'hCAFE_F00D);
      chk("rstall mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("rstall in_ready",  {31'd0, bus.in_ready}, 32'd0);
      if (c == 2) bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall done in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("stall done out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("stall single resp", {31'd0, bus.out_valid}, 32'd0);

    // Reset during BUS
    bus.in_valid  = 1'b1;
    bus.in_store  = 1'b1;
    bus.in_funct3 = 3'b010;
    bus.in_addr   = 32'h0000_6000;
    bus.in_wdata  = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-rst mem_valid", {31'd0, bus.mem_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midbus rst mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("midbus rst wstrb",     {28'd0, bus.mem_wstrb}, 32'd0);
    chk("midbus rst mem_we",    {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-rst in_ready",  {31'd0, bus.in_ready}, 32'd1);
      chk("post-rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
